// File: rtl/axi4_write_responder_if.sv
// AW/W/B channel bundle for the write responder; master drives requests and data, slave answers.
interface axi4_write_responder_if;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [63:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic        WLAST;
    logic [7:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;

    modport master (
        output AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        output WDATA, WVALID, WLAST, WSTRB, BREADY,
        input  AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST,
        input  WDATA, WVALID, WLAST, WSTRB, BREADY,
        output AWREADY, WREADY, BVALID, BRESP
    );
endinterface

// File: rtl/axi4_write_responder.sv
// AXI4 write-only slave into a 2^DEPTH_LOG2 x 64-bit memory; bad bursts are drained, answered SLVERR.
// Latency: BVALID one cycle after the last beat, dbg_rdata one cycle after dbg_addr.
// Backpressure: AW stalls from acceptance until one cycle after the B handshake; BVALID holds until BREADY.
// Optional: define AXI_WR_PROTOCOL_CHECK_EN to treat misplaced WLAST as SLVERR with sticky prot_err.
module axi4_write_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
    parameter int          DEPTH_LOG2 = 18
) (
    input  logic                  clk_100Mhz,
    input  logic                  rst,
    axi4_write_responder_if.slave bus,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [63:0]           dbg_rdata,
    output logic [31:0]           burst_cnt,
    output logic                  prot_err
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    localparam logic [39:0] MEM_BYTES = 40'd1 << (DEPTH_LOG2 + 3);

    state_t                state_q, state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [31:0]           burst_cnt_q, burst_cnt_d;
    logic                  prot_err_q, prot_err_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            len_q, len_d;
    logic [DEPTH_LOG2-1:0] widx_q, widx_d;
    logic                  bad_q, bad_d;
    logic [63:0]           dbg_rdata_q;

    logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic [31:0] off_w;
    logic [39:0] end_off_w;
    logic        aw_bad_w;
    logic        aw_hs_w;
    logic        w_hs_w;
    logic        last_beat_w;
    logic        beat_perr_w;
    logic        mem_we_w;

    // The whole burst lies in one contiguous range, so checking its last byte offset covers every beat.
    assign off_w      = bus.AWADDR - BASE_ADDR;
    assign end_off_w  = {8'd0, off_w} + {29'd0, bus.AWLEN, 3'd0};
    assign aw_bad_w   = (bus.AWSIZE != 3'b011) || (bus.AWBURST != 2'b01) ||
                        (bus.AWADDR[2:0] != 3'd0) || (bus.AWADDR < BASE_ADDR) ||
                        (end_off_w >= MEM_BYTES);

    assign aw_hs_w     = bus.AWVALID && awready_q;
    assign w_hs_w      = bus.WVALID && wready_q;
    assign last_beat_w = (cnt_q == len_q);

`ifdef AXI_WR_PROTOCOL_CHECK_EN
    assign beat_perr_w = w_hs_w && (bus.WLAST != last_beat_w);
`else
    logic unused_wlast;
    assign unused_wlast = bus.WLAST;
    assign beat_perr_w  = 1'b0;
`endif

    assign mem_we_w = w_hs_w && !bad_q && !beat_perr_w;

    always_comb begin
        state_d     = state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        burst_cnt_d = burst_cnt_q;
        prot_err_d  = prot_err_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        widx_d      = widx_q;
        bad_d       = bad_q;
        case (state_q)
            IDLE: begin
                if (aw_hs_w) begin
                    state_d   = DATA;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    cnt_d     = 8'd0;
                    len_d     = bus.AWLEN;
                    widx_d    = off_w[DEPTH_LOG2+2:3];
                    bad_d     = aw_bad_w;
                end
            end
            DATA: begin
                if (w_hs_w) begin
                    cnt_d  = cnt_q + 8'd1;
                    widx_d = widx_q + DEPTH_LOG2'(1);
                    if (beat_perr_w) begin
                        bad_d      = 1'b1;
                        prot_err_d = 1'b1;
                    end
                    if (last_beat_w) begin
                        state_d  = RESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = (bad_q || beat_perr_w) ? 2'b10 : 2'b00;
                    end
                end
            end
            RESP: begin
                if (bus.BREADY) begin
                    state_d     = IDLE;
                    bvalid_d    = 1'b0;
                    awready_d   = 1'b1;
                    burst_cnt_d = burst_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            burst_cnt_q <= 32'd0;
            prot_err_q  <= 1'b0;
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            widx_q      <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            burst_cnt_q <= burst_cnt_d;
            prot_err_q  <= prot_err_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            widx_q      <= widx_d;
            bad_q       <= bad_d;
        end
    end

    // Memory has no reset so contents survive rst; the read port sees pre-write data on a same-cycle hit.
    always_ff @(posedge clk_100Mhz) begin
        if (mem_we_w) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.WSTRB[i]) begin
                    mem[widx_q][8*i +: 8] <= bus.WDATA[8*i +: 8];
                end
            end
        end
        dbg_rdata_q <= mem[dbg_addr];
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign dbg_rdata   = dbg_rdata_q;
    assign burst_cnt   = burst_cnt_q;
    assign prot_err    = prot_err_q;

endmodule

// File: tb/tb_axi4_write_responder.sv
// Directed bench for axi4_write_responder: B responses and backdoor reads are scoreboarded by monitors.
module tb_axi4_write_responder;

    logic        clk_100Mhz = 1'b0;
    logic        rst;
    logic [17:0] dbg_addr;
    logic [63:0] dbg_rdata;
    logic [31:0] burst_cnt;
    logic        prot_err;

    always #5 clk_100Mhz = ~clk_100Mhz;

    axi4_write_responder_if bus();

    axi4_write_responder #(
        .BASE_ADDR  (32'h0100_0000),
        .DEPTH_LOG2 (18)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .rst        (rst),
        .bus        (bus),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata),
        .burst_cnt  (burst_cnt),
        .prot_err   (prot_err)
    );

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    int          exp_bursts = 0;
    logic [1:0]  exp_b[$];
    logic [63:0] exp_rd[$];
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: got timeout/unexpected expected handshake", name);
    endtask

    // B monitor: one comparison per handshake cycle
    always begin
        @(negedge clk_100Mhz);
        #1;
        if (bus.BVALID && bus.BREADY) begin
            if (exp_b.size() == 0) fail_now("unexpected_bresp");
            else chk("bresp", {62'd0, bus.BRESP}, {62'd0, exp_b.pop_front()});
        end
    end

    // Backdoor read monitor: data is due one cycle after the address was presented
    always begin
        @(negedge clk_100Mhz);
        #1;
        if (rd_pend) begin
            if (exp_rd.size() == 0) fail_now("unexpected_read");
            else chk("dbg_rdata", dbg_rdata, exp_rd.pop_front());
        end
        rd_pend = rd_req;
    end

    task automatic rd(input logic [17:0] a, input logic [63:0] e);
        @(negedge clk_100Mhz);
        dbg_addr = a;
        rd_req   = 1'b1;
        exp_rd.push_back(e);
    endtask

    task automatic rd_done();
        @(negedge clk_100Mhz);
        rd_req = 1'b0;
        @(negedge clk_100Mhz);
    endtask

    // nb beats are driven; a response is expected only when the burst is complete (nb == len+1)
    task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] bt, input logic [63:0] d0, input logic [7:0] strb,
                         input int last_at, input int nb, input logic [1:0] resp);
        int to;
        if (nb == int'(len) + 1) begin
            exp_b.push_back(resp);
            exp_bursts++;
        end
        @(negedge clk_100Mhz);
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        bus.AWSIZE  = size;
        bus.AWBURST = bt;
        bus.AWVALID = 1'b1;
        to = 0;
        while (!bus.AWREADY && to < 100) begin
            @(negedge clk_100Mhz);
            to++;
        end
        if (to >= 100) begin
            fail_now("aw_timeout");
            bus.AWVALID = 1'b0;
            return;
        end
        @(negedge clk_100Mhz);
        bus.AWVALID = 1'b0;
        for (int k = 0; k < nb; k++) begin
            bus.WVALID = 1'b1;
            bus.WDATA  = d0 + 64'(k);
            bus.WSTRB  = strb;
            bus.WLAST  = (k == last_at);
            to = 0;
            while (!bus.WREADY && to < 100) begin
                @(negedge clk_100Mhz);
                to++;
            end
            if (to >= 100) begin
                fail_now("w_timeout");
                bus.WVALID = 1'b0;
                return;
            end
            @(negedge clk_100Mhz);
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        if (nb == int'(len) + 1) begin
            chk("bvalid_after_last", {63'd0, bus.BVALID}, 64'd1);
            chk("wready_in_resp", {63'd0, bus.WREADY}, 64'd0);
        end
    endtask

    task automatic wait_idle();
        int to;
        to = 0;
        while (!(bus.AWREADY && !bus.BVALID) && to < 100) begin
            @(negedge clk_100Mhz);
            to++;
        end
        if (to >= 100) fail_now("idle_timeout");
    endtask

    task automatic chk_reset_state();
        chk("rst_awready", {63'd0, bus.AWREADY}, 64'd1);
        chk("rst_wready", {63'd0, bus.WREADY}, 64'd0);
        chk("rst_bvalid", {63'd0, bus.BVALID}, 64'd0);
        chk("rst_bresp", {62'd0, bus.BRESP}, 64'd0);
        chk("rst_burst_cnt", {32'd0, burst_cnt}, 64'd0);
        chk("rst_prot_err", {63'd0, prot_err}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_b;
        rst         = 1'b1;
        dbg_addr    = '0;
        bus.AWADDR  = '0;
        bus.AWVALID = 1'b0;
        bus.AWLEN   = '0;
        bus.AWSIZE  = '0;
        bus.AWBURST = '0;
        bus.WDATA   = '0;
        bus.WVALID  = 1'b0;
        bus.WLAST   = 1'b0;
        bus.WSTRB   = '0;
        bus.BREADY  = 1'b1;
        repeat (3) @(negedge clk_100Mhz);
        chk_reset_state();
        rst = 1'b0;
        @(negedge clk_100Mhz);

        // 16-beat INCR burst, data = beat index
        burst(32'h0100_0000, 8'd15, 3'b011, 2'b01, 64'd0, 8'hFF, 15, 16, 2'b00);
        wait_idle();
        chk("burst_cnt_1", {32'd0, burst_cnt}, 64'd1);
        for (int k = 0; k < 16; k++) rd(18'(k), 64'(k));
        rd_done();

        // second frame buffer: full write, then lower-half strobe, then zero strobe
        burst(32'h0110_0000, 8'd0, 3'b011, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 0, 1, 2'b00);
        burst(32'h0110_0000, 8'd0, 3'b011, 2'b01, 64'h1122_3344_5566_7788, 8'h0F, 0, 1, 2'b00);
        burst(32'h0110_0000, 8'd0, 3'b011, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 1, 2'b00);
        wait_idle();
        rd(18'h20000, 64'hAAAA_BBBB_5566_7788);
        rd_done();

        // bad bursts, several aliasing onto words already written
        burst(32'h0200_0000, 8'd3, 3'b011, 2'b01, 64'h99, 8'hFF, 3, 4, 2'b10);
        burst(32'h0100_0008, 8'd0, 3'b010, 2'b01, 64'h99, 8'hFF, 0, 1, 2'b10);
        burst(32'h0100_0010, 8'd0, 3'b011, 2'b10, 64'h99, 8'hFF, 0, 1, 2'b10);
        burst(32'h0100_0019, 8'd0, 3'b011, 2'b01, 64'h99, 8'hFF, 0, 1, 2'b10);
        burst(32'h011F_FFF8, 8'd0, 3'b011, 2'b01, 64'h5A5A, 8'hFF, 0, 1, 2'b00);
        burst(32'h011F_FFF0, 8'd2, 3'b011, 2'b01, 64'h77, 8'hFF, 2, 3, 2'b10);
        burst(32'h00FF_FFF8, 8'd0, 3'b011, 2'b01, 64'h66, 8'hFF, 0, 1, 2'b10);
        wait_idle();
        chk("burst_cnt_bad", {32'd0, burst_cnt}, 64'(exp_bursts));
        for (int k = 0; k < 4; k++) rd(18'(k), 64'(k));
        rd(18'h3FFFF, 64'h5A5A);
        rd_done();

        // B backpressure: response held, next AW stalled until after the handshake
        bus.BREADY = 1'b0;
        burst(32'h0200_0000, 8'd0, 3'b011, 2'b01, 64'h1, 8'hFF, 0, 1, 2'b10);
        bus.AWADDR  = 32'h0100_0100;
        bus.AWLEN   = 8'd0;
        bus.AWSIZE  = 3'b011;
        bus.AWBURST = 2'b01;
        bus.AWVALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100Mhz);
            chk("hold_bvalid", {63'd0, bus.BVALID}, 64'd1);
            chk("hold_bresp", {62'd0, bus.BRESP}, 64'd2);
            chk("hold_awready", {63'd0, bus.AWREADY}, 64'd0);
        end
        bus.BREADY = 1'b1;
        @(negedge clk_100Mhz);
        chk("awready_after_b", {63'd0, bus.AWREADY}, 64'd1);
        chk("bvalid_after_b", {63'd0, bus.BVALID}, 64'd0);
        bus.AWVALID = 1'b0;
        burst(32'h0100_0100, 8'd0, 3'b011, 2'b01, 64'hBEEF, 8'hFF, 0, 1, 2'b00);
        wait_idle();
        rd(18'h20, 64'hBEEF);
        rd_done();

`ifdef AXI_WR_PROTOCOL_CHECK_EN
        burst(32'h0100_0600, 8'd7, 3'b011, 2'b01, 64'h300, 8'hFF, 3, 8, 2'b10);
        wait_idle();
        chk("prot_err_set", {63'd0, prot_err}, 64'd1);
        burst(32'h0100_0700, 8'd0, 3'b011, 2'b01, 64'h400, 8'hFF, 0, 1, 2'b00);
        wait_idle();
        chk("prot_err_sticky", {63'd0, prot_err}, 64'd1);
`else
        burst(32'h0100_0600, 8'd3, 3'b011, 2'b01, 64'h300, 8'hFF, 1, 4, 2'b00);
        wait_idle();
        chk("prot_err_tied", {63'd0, prot_err}, 64'd0);
        for (int k = 0; k < 4; k++) rd(18'h0C0 + 18'(k), 64'h300 + 64'(k));
        rd_done();
`endif
        chk("burst_cnt_pre_rst", {32'd0, burst_cnt}, 64'(exp_bursts));

        // reset after beat 5 of a 16-beat burst
        burst(32'h0100_0400, 8'd15, 3'b011, 2'b01, 64'd100, 8'hFF, 15, 6, 2'b00);
        rst = 1'b1;
        exp_bursts = 0;
        @(negedge clk_100Mhz);
        @(negedge clk_100Mhz);
        chk_reset_state();
        rst = 1'b0;
        saw_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_100Mhz);
            if (bus.BVALID) saw_b = 1'b1;
        end
        chk("no_b_after_rst", {63'd0, saw_b}, 64'd0);
        chk("awready_after_rst", {63'd0, bus.AWREADY}, 64'd1);
        for (int k = 0; k < 6; k++) rd(18'h080 + 18'(k), 64'd100 + 64'(k));
        rd_done();

        repeat (3) @(negedge clk_100Mhz);
        chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
        chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/axi4_write_responder.md
AXI4_WRITE_RESPONDER -- requirements
Module: axi4_write_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0100_0000: byte address of memory word 0.
REQ-002 Parameter DEPTH_LOG2, default 18: memory holds 2^DEPTH_LOG2 64-bit words, covering 0x0100_0000-0x011F_FFFF for both frame buffers.
REQ-003 clk_100Mhz  in  1  sole clock; all ports sampled or driven on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 AWADDR  in  32  burst start byte address.
REQ-006 AWVALID  in  1  address valid.
REQ-007 AWREADY  out  1  address accepted.
REQ-008 AWLEN  in  8  beats minus one.
REQ-009 AWSIZE  in  3  beat size; 3'b011 is the only supported value.
REQ-010 AWBURST  in  2  burst type; 2'b01 (INCR) is the only supported value.
REQ-011 WDATA  in  64  write data.
REQ-012 WVALID  in  1  data valid.
REQ-013 WREADY  out  1  data accepted.
REQ-014 WLAST  in  1  final beat marker.
REQ-015 WSTRB  in  8  byte enables; bit n gates WDATA[8n+7:8n].
REQ-016 BVALID  out  1  response valid.
REQ-017 BREADY  in  1  response accepted.
REQ-018 BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-019 dbg_addr  in  DEPTH_LOG2  backdoor word index.
REQ-020 dbg_rdata  out  64  word at dbg_addr, one-cycle registered latency.
REQ-021 burst_cnt  out  32  completed bursts, wraps at 2^32.
REQ-022 prot_err  out  1  sticky protocol-error flag.

Function
REQ-023 The FSM SHALL have three states: IDLE, DATA and RESP.
REQ-024 In IDLE, AWREADY SHALL be 1; on AWVALID&&AWREADY, the block SHALL latch AWADDR/AWLEN/AWSIZE/AWBURST, clear the beat counter, and enter DATA on the next cycle.
REQ-025 In DATA, WREADY SHALL be 1 and AWREADY 0; each WVALID&&WREADY cycle is one beat.
REQ-026 Beat k SHALL write word index (((AWADDR-BASE_ADDR)>>3)+k) mod 2^DEPTH_LOG2, byte-masked by WSTRB; WSTRB=0 writes nothing.
REQ-027 A burst SHALL be "bad" if AWSIZE!=3'b011, AWBURST!=2'b01, AWADDR[2:0]!=0, or any beat address falls outside [BASE_ADDR, BASE_ADDR+8*2^DEPTH_LOG2); bad beats SHALL be accepted but not written.
REQ-028 DATA SHALL exit to RESP after the beat with count==AWLEN; BVALID SHALL assert the next cycle.
REQ-029 In RESP, WREADY SHALL be 0 and BVALID SHALL be held stable until BREADY; on BVALID&&BREADY the block SHALL return to IDLE, and AWREADY SHALL be 1 the following cycle.
REQ-030 BRESP SHALL be SLVERR for a bad burst, and OKAY otherwise.
REQ-031 burst_cnt SHALL increment by 1 on each B handshake, whether the response is OKAY or SLVERR.
REQ-032 WVALID in IDLE or RESP SHALL NOT be accepted; AWVALID in DATA or RESP SHALL stall until IDLE.
REQ-033 A DATA-state beat written to the same index that dbg_addr reads in the same cycle SHALL return the old word on dbg_rdata.

Reset
REQ-034 While rst=1, the block SHALL force: state IDLE, AWREADY 1, WREADY 0, BVALID 0, BRESP 2'b00, burst_cnt 0, prot_err 0, beat counter 0.
REQ-035 Reset SHALL NOT clear memory contents; reset mid-burst SHALL abandon the burst, keep beats already written, and issue no B response.

Configuration
REQ-036 With macro AXI_WR_PROTOCOL_CHECK_EN defined, WLAST=1 on a beat other than AWLEN, or WLAST=0 on beat AWLEN, SHALL make the burst bad (SLVERR) and set prot_err until reset; beat counting (REQ-028) SHALL be unchanged.
REQ-037 Without AXI_WR_PROTOCOL_CHECK_EN, WLAST SHALL be ignored and prot_err SHALL be tied to 0.

Verification
REQ-038 AW 0x0100_0000 LEN=15 SIZE=3 INCR, WDATA=beat index, WSTRB=FF, BREADY=1 -> 16 beats accepted, BVALID one cycle after beat 15 with BRESP=00, dbg_addr 0..15 reads 0..15, burst_cnt=1.
REQ-039 AW 0x0110_0000 LEN=0, WDATA=64'h1122334455667788, WSTRB=8'h0F over an existing word 0 -> dbg_addr 0x20000 reads upper 32 bits unchanged, lower 32 bits = 55667788.
REQ-040 AW 0x0200_0000 LEN=3 -> 4 beats accepted, memory unchanged, BRESP=10, burst_cnt increments.
REQ-041 BREADY held 0 for 10 cycles after BVALID -> BVALID and BRESP stay stable, second AWVALID not accepted until 1 cycle after the B handshake.
REQ-042 With the macro defined, LEN=7 and WLAST on beat 3 -> 8 beats accepted, BRESP=10, prot_err=1 until rst.
REQ-043 rst pulse after beat 5 of LEN=15 -> BVALID never asserts, words 0-5 retained, AWREADY=1 after reset release.
